fis_batch_ctrl: RTL and testbench
=================================

Name: fis_batch_ctrl

Overview:
Parametrised batch sequencer for the HLS fuzzy-inference core.
- Runs the core back-to-back over a batch of input samples, selecting one sample per run through `sample_idx`.
- After each run it performs a configurable gap/reset sequence on the core.
- Buffers each `ap_return` in a result FIFO.
- Tracks per-run processing time (min/max), run timeouts and abort requests.
- Sits between the host/localbus register layer and the core plus its DRAMs, replacing single-shot start/done handling.

Parameters:
DATA_W, 32, width of core `ap_return` and result FIFO entries
RES_DEPTH, 16, result FIFO depth (power of 2, ≥2)
RST_GAP, 2, cycles with core reset low between capture and core reset (≥1)
RST_HOLD, 4, cycles core reset held high after each run (≥1)
TIMEOUT_CYC, 65535, max cycles per run before timeout (≥2)
IDX_W, 16, width of batch length / sample index

Ports:
usr_synclk  in  1  clock
sys_rst_p  in  1  synchronous active-high reset
batch_start  in  1  1-cycle pulse; accepted only in IDLE
batch_len  in  IDX_W  samples per batch; sampled on accepted batch_start
abort  in  1  1-cycle pulse; request stop after current run
core_ap_start  out  1  core ap_start
core_ap_rst  out  1  core ap_rst
core_ap_ready  in  1  core ap_ready
core_ap_done  in  1  core ap_done (1-cycle pulse)
core_ap_return  in  DATA_W  core result, valid with core_ap_done
sample_idx  out  IDX_W  current sample index, drives input-data DRAM upper address
busy  out  1  high in every state except IDLE
batch_done  out  1  level; set at FIN, cleared on next accepted batch_start
err_timeout  out  1  sticky; a run exceeded TIMEOUT_CYC
aborted  out  1  sticky; batch ended by abort
res_rd  in  1  pop result FIFO
res_dout  out  DATA_W  FIFO head (show-ahead), valid when !res_empty
res_empty  out  1  FIFO empty
res_count  out  clog2(RES_DEPTH)+1  FIFO occupancy
prs_time_min  out  32  minimum captured run time in batch
prs_time_max  out  32  maximum captured run time in batch

Behaviour:
- All outputs are registered except `res_dout`, `res_empty` and `res_count`, which derive from FIFO registers.
- Reset values:
  - state IDLE, `sample_idx` 0, `core_ap_start` 0, `core_ap_rst` 1 (drops to 0 on the first cycle after reset).
  - `busy` 0, `batch_done` 0, `err_timeout` 0, `aborted` 0.
  - FIFO empty with `res_count` 0, `prs_time_min` 0xFFFFFFFF, `prs_time_max` 0.
- Reset mid-batch: returns to the reset state in one cycle. FIFO contents are discarded.
- States: IDLE, START, WAIT, CAPT, GAP, CRST, FIN.
- IDLE:
  - `batch_start` with `batch_len` != 0 → START. Clears FIFO, flags, `sample_idx`, min/max and abort_pending.
  - `batch_start` with `batch_len` == 0 → FIN (same clears).
- START:
  - `core_ap_start` = 1. Run timer = 1 on entry and +1 per cycle in START/WAIT.
  - `core_ap_ready` → WAIT.
  - If `core_ap_done` is in the same cycle, latch return and timer, → CAPT.
- WAIT:
  - `core_ap_start` = 0.
  - `core_ap_done` → latch `core_ap_return` and timer value, → CAPT.
  - Timer == TIMEOUT_CYC without done → set `err_timeout`, → GAP, no capture.
- CAPT:
  - If FIFO not full, or full with `res_rd` this cycle: push latched return, update min/max with latched time, → GAP.
  - Otherwise stall in CAPT. No data loss; core is held.
- GAP: RST_GAP cycles, `core_ap_rst` = 0, then → CRST.
- CRST: RST_HOLD cycles, `core_ap_rst` = 1. At the end:
  - If `err_timeout`, abort_pending, or `sample_idx` == `batch_len`−1 → FIN.
  - Else `sample_idx`+1 → START.
- FIN: set `batch_done`; set `aborted` if abort_pending; → IDLE next cycle.
- `abort`: ignored in IDLE/FIN. Otherwise sets abort_pending; the current run still completes and is captured.
- FIFO:
  - Simultaneous push and pop keeps `res_count` unchanged.
  - `res_rd` while empty is ignored.
  - Pointers wrap modulo RES_DEPTH.
- Fixed per-run overhead: timer + 1 (CAPT, no stall) + RST_GAP + RST_HOLD cycles.

Test Plan:
- Core model: ready on first START cycle, done 6 cycles after START entry, returns 0x100+idx. Stimulus: `batch_len`=3 → FIFO holds 0x100, 0x101, 0x102; `res_count`=3; min=max=7; `batch_done`=1; `sample_idx`=2; successive START entries 14 cycles apart.
- Same core model, run times 5, 9, 3 → `prs_time_min`=3, `prs_time_max`=9.
- RES_DEPTH=16, `batch_len`=20, no `res_rd` → stall in CAPT with `res_count`=16 and `core_ap_rst`=0. Then pop 4 → all 20 results eventually read in order, no loss.
- TIMEOUT_CYC=50, core never asserts done → `err_timeout`=1 at timer 50; RST_HOLD reset pulse observed; `batch_done`=1; FIFO empty.
- `abort` during run 1 of `batch_len`=5 → runs 0 and 1 captured, `aborted`=1, `sample_idx`=1.
- `sys_rst_p` in WAIT of run 2 → next cycle all outputs at reset values. `batch_start` during `busy` ignored. `batch_len`=0 → `batch_done` with no `core_ap_start`.

Source files
------------

// File: rtl/fis_batch_ctrl.sv
// Batch sequencer for the fuzzy-inference core: runs the core once per sample,
// buffers each result in a show-ahead FIFO and tracks per-run timing.
//
// state | meaning
// IDLE  | waiting for batch_start
// START | core_ap_start high, run timer counting
// WAIT  | core running, waiting for ap_done or timeout
// CAPT  | push latched result into FIFO (stalls while FIFO full)
// GAP   | core reset low for RST_GAP cycles
// CRST  | core reset high for RST_HOLD cycles, then next sample or finish
// FIN   | flag batch completion, back to IDLE
module fis_batch_ctrl #(
    parameter int DATA_W      = 32,
    parameter int RES_DEPTH   = 16,
    parameter int RST_GAP     = 2,
    parameter int RST_HOLD    = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int IDX_W       = 16
) (
    input  logic                         usr_synclk,
    input  logic                         sys_rst_p,
    input  logic                         batch_start,
    input  logic [IDX_W-1:0]             batch_len,
    input  logic                         abort,
    output logic                         core_ap_start,
    output logic                         core_ap_rst,
    input  logic                         core_ap_ready,
    input  logic                         core_ap_done,
    input  logic [DATA_W-1:0]            core_ap_return,
    output logic [IDX_W-1:0]             sample_idx,
    output logic                         busy,
    output logic                         batch_done,
    output logic                         err_timeout,
    output logic                         aborted,
    input  logic                         res_rd,
    output logic [DATA_W-1:0]            res_dout,
    output logic                         res_empty,
    output logic [$clog2(RES_DEPTH):0]   res_count,
    output logic [31:0]                  prs_time_min,
    output logic [31:0]                  prs_time_max
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_CAPT, S_GAP, S_CRST, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    sample_idx_q, sample_idx_d;
    logic [IDX_W-1:0]    batch_len_q, batch_len_d;
    logic [31:0]         timer_q, timer_d;
    logic [31:0]         seq_cnt_q, seq_cnt_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d;
    logic [31:0]         cap_time_q, cap_time_d;
    logic                abort_pend_q, abort_pend_d;
    logic                start_q, start_d;
    logic                rst_q, rst_d;
    logic                busy_q, busy_d;
    logic                batch_done_q, batch_done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                aborted_q, aborted_d;
    logic [31:0]         min_q, min_d;
    logic [31:0]         max_q, max_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [RES_DEPTH];
    logic                push, pop, clear, full;

    assign full = (count_q == CNT_W'(RES_DEPTH));

    // Next-state, counters, flags and FIFO pointer arithmetic.
    always_comb begin
        state_d       = state_q;
        sample_idx_d  = sample_idx_q;
        batch_len_d   = batch_len_q;
        timer_d       = timer_q;
        seq_cnt_d     = seq_cnt_q;
        cap_data_d    = cap_data_q;
        cap_time_d    = cap_time_q;
        abort_pend_d  = abort_pend_q;
        batch_done_d  = batch_done_q;
        err_timeout_d = err_timeout_q;
        aborted_d     = aborted_q;
        min_d         = min_q;
        max_d         = max_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        clear         = 1'b0;
        push          = 1'b0;
        pop           = res_rd && (count_q != '0);

        if (abort && state_q != S_IDLE && state_q != S_FIN) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    clear         = 1'b1;
                    batch_len_d   = batch_len;
                    sample_idx_d  = '0;
                    batch_done_d  = 1'b0;
                    err_timeout_d = 1'b0;
                    aborted_d     = 1'b0;
                    abort_pend_d  = 1'b0;
                    min_d         = 32'hFFFF_FFFF;
                    max_d         = 32'h0;
                    if (batch_len != '0) begin
                        state_d = S_START;
                        timer_d = 32'd1;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_START, S_WAIT: begin
                timer_d = timer_q + 32'd1;
                if (core_ap_done) begin
                    cap_data_d = core_ap_return;
                    cap_time_d = timer_q;
                    state_d    = S_CAPT;
                end else if (state_q == S_START && core_ap_ready) begin
                    state_d = S_WAIT;
                end else if (timer_q == 32'(TIMEOUT_CYC)) begin
                    // Also applies in START so a core that never goes ready cannot hang the batch.
                    err_timeout_d = 1'b1;
                    seq_cnt_d     = 32'(RST_GAP - 1);
                    state_d       = S_GAP;
                end
            end
            S_CAPT: begin
                if (!full || pop) begin
                    push      = 1'b1;
                    if (cap_time_q < min_q) min_d = cap_time_q;
                    if (cap_time_q > max_q) max_d = cap_time_q;
                    seq_cnt_d = 32'(RST_GAP - 1);
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (seq_cnt_q == 32'd0) begin
                    seq_cnt_d = 32'(RST_HOLD - 1);
                    state_d   = S_CRST;
                end else begin
                    seq_cnt_d = seq_cnt_q - 32'd1;
                end
            end
            S_CRST: begin
                if (seq_cnt_q == 32'd0) begin
                    if (err_timeout_q || abort_pend_d ||
                        sample_idx_q == batch_len_q - IDX_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        sample_idx_d = sample_idx_q + IDX_W'(1);
                        timer_d      = 32'd1;
                        state_d      = S_START;
                    end
                end else begin
                    seq_cnt_d = seq_cnt_q - 32'd1;
                end
            end
            S_FIN: begin
                batch_done_d = 1'b1;
                if (abort_pend_q) aborted_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end

        start_d = (state_d == S_START);
        rst_d   = (state_d == S_CRST);
        busy_d  = (state_d != S_IDLE);
    end

    // Register all state, flags and outputs; synchronous reset.
    always_ff @(posedge usr_synclk) begin
        if (sys_rst_p) begin
            state_q       <= S_IDLE;
            sample_idx_q  <= '0;
            batch_len_q   <= '0;
            timer_q       <= '0;
            seq_cnt_q     <= '0;
            cap_data_q    <= '0;
            cap_time_q    <= '0;
            abort_pend_q  <= 1'b0;
            start_q       <= 1'b0;
            rst_q         <= 1'b1;
            busy_q        <= 1'b0;
            batch_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            aborted_q     <= 1'b0;
            min_q         <= 32'hFFFF_FFFF;
            max_q         <= 32'h0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            sample_idx_q  <= sample_idx_d;
            batch_len_q   <= batch_len_d;
            timer_q       <= timer_d;
            seq_cnt_q     <= seq_cnt_d;
            cap_data_q    <= cap_data_d;
            cap_time_q    <= cap_time_d;
            abort_pend_q  <= abort_pend_d;
            start_q       <= start_d;
            rst_q         <= rst_d;
            busy_q        <= busy_d;
            batch_done_q  <= batch_done_d;
            err_timeout_q <= err_timeout_d;
            aborted_q     <= aborted_d;
            min_q         <= min_d;
            max_q         <= max_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Result storage; contents need no reset since occupancy is tracked by count_q.
    always_ff @(posedge usr_synclk) begin
        if (push) mem_q[wr_ptr_q] <= cap_data_q;
    end

    assign core_ap_start = start_q;
    assign core_ap_rst   = rst_q;
    assign sample_idx    = sample_idx_q;
    assign busy          = busy_q;
    assign batch_done    = batch_done_q;
    assign err_timeout   = err_timeout_q;
    assign aborted       = aborted_q;
    assign res_dout      = mem_q[rd_ptr_q];
    assign res_empty     = (count_q == '0);
    assign res_count     = count_q;
    assign prs_time_min  = min_q;
    assign prs_time_max  = max_q;

endmodule

// File: tb/tb_fis_batch_ctrl.sv
// Bench for fis_batch_ctrl: behavioural core model plus per-scenario checks.
module tb_fis_batch_ctrl;
    localparam int DATA_W      = 32;
    localparam int RES_DEPTH   = 16;
    localparam int RST_GAP     = 2;
    localparam int RST_HOLD    = 4;
    localparam int TIMEOUT_CYC = 50;
    localparam int IDX_W       = 16;
    localparam int OVERHEAD    = 1 + RST_GAP + RST_HOLD;

    logic                        usr_synclk = 1'b0;
    logic                        sys_rst_p = 1'b1;
    logic                        batch_start = 1'b0;
    logic [IDX_W-1:0]            batch_len = '0;
    logic                        abort = 1'b0;
    logic                        core_ap_start, core_ap_rst;
    logic                        core_ap_ready = 1'b0;
    logic                        core_ap_done = 1'b0;
    logic [DATA_W-1:0]           core_ap_return = '0;
    logic [IDX_W-1:0]            sample_idx;
    logic                        busy, batch_done, err_timeout, aborted;
    logic                        res_rd = 1'b0;
    logic [DATA_W-1:0]           res_dout;
    logic                        res_empty;
    logic [$clog2(RES_DEPTH):0]  res_count;
    logic [31:0]                 prs_time_min, prs_time_max;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    // Core model state: per-run time table, run entry cycle log, return base.
    int          rt_tab[$];
    int          entry_q[$];
    logic [31:0] got_q[$];
    int          run_no = 0;
    logic [31:0] base = 32'h100;
    bit          running = 0;
    bit          start_prev = 0;
    int          run_cyc = 0;
    int          cur_rt = 0;

    fis_batch_ctrl #(
        .DATA_W(DATA_W), .RES_DEPTH(RES_DEPTH), .RST_GAP(RST_GAP),
        .RST_HOLD(RST_HOLD), .TIMEOUT_CYC(TIMEOUT_CYC), .IDX_W(IDX_W)
    ) dut (
        .usr_synclk(usr_synclk), .sys_rst_p(sys_rst_p),
        .batch_start(batch_start), .batch_len(batch_len), .abort(abort),
        .core_ap_start(core_ap_start), .core_ap_rst(core_ap_rst),
        .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done),
        .core_ap_return(core_ap_return), .sample_idx(sample_idx),
        .busy(busy), .batch_done(batch_done), .err_timeout(err_timeout),
        .aborted(aborted), .res_rd(res_rd), .res_dout(res_dout),
        .res_empty(res_empty), .res_count(res_count),
        .prs_time_min(prs_time_min), .prs_time_max(prs_time_max)
    );

    always #5 usr_synclk = ~usr_synclk;

    always @(posedge usr_synclk) cyc_cnt <= cyc_cnt + 1;

    // Core model: ready on the first START cycle, done (run time - 1) cycles later,
    // a run time of 0 means the core never finishes.
    always @(negedge usr_synclk) begin
        core_ap_ready = 1'b0;
        core_ap_done  = 1'b0;
        if (sys_rst_p || core_ap_rst) running = 0;
        if (core_ap_start && !start_prev) begin
            running = 1;
            run_cyc = 0;
            cur_rt  = (run_no < rt_tab.size()) ? rt_tab[run_no] : 7;
            run_no++;
            entry_q.push_back(cyc_cnt);
            core_ap_ready = 1'b1;
        end else if (running) begin
            run_cyc++;
        end
        if (running && cur_rt != 0 && run_cyc == cur_rt - 1) begin
            core_ap_done   = 1'b1;
            core_ap_return = base + 32'(sample_idx);
            running = 0;
        end
        start_prev = core_ap_start;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic new_batch(input logic [31:0] b);
        rt_tab.delete();
        entry_q.delete();
        run_no = 0;
        base   = b;
    endtask

    task automatic start_batch(input int len);
        @(negedge usr_synclk);
        batch_start = 1'b1;
        batch_len   = IDX_W'(len);
        @(negedge usr_synclk);
        batch_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge usr_synclk);
            if (batch_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic drain(input int n, input int budget);
        got_q.delete();
        for (int i = 0; i < budget && got_q.size() < n; i++) begin
            @(negedge usr_synclk);
            if (!res_empty) begin
                got_q.push_back(res_dout);
                res_rd = 1'b1;
            end else begin
                res_rd = 1'b0;
            end
        end
        @(negedge usr_synclk);
        res_rd = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_p = 1'b1;
        repeat (2) @(negedge usr_synclk);
        n_checks++; if (core_ap_rst !== 1'b1) begin n_errors++; $display("FAIL reset_ap_rst: got %b expected 1", core_ap_rst); end
        n_checks++; if (core_ap_start !== 1'b0) begin n_errors++; $display("FAIL reset_ap_start: got %b expected 0", core_ap_start); end
        n_checks++; if ({busy, batch_done, err_timeout, aborted} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, batch_done, err_timeout, aborted}); end
        n_checks++; if (res_empty !== 1'b1 || res_count !== 0) begin n_errors++; $display("FAIL reset_fifo: got empty=%b count=%0d expected empty=1 count=0", res_empty, res_count); end
        n_checks++; if (prs_time_min !== 32'hFFFF_FFFF || prs_time_max !== 32'h0) begin n_errors++; $display("FAIL reset_minmax: got %h/%h expected ffffffff/00000000", prs_time_min, prs_time_max); end
        n_checks++; if (sample_idx !== 0) begin n_errors++; $display("FAIL reset_idx: got %0d expected 0", sample_idx); end
        sys_rst_p = 1'b0;
        @(negedge usr_synclk);
        n_checks++; if (core_ap_rst !== 1'b0) begin n_errors++; $display("FAIL reset_ap_rst_release: got %b expected 0", core_ap_rst); end
    endtask

    task automatic test_basic();
        bit ok;
        new_batch(32'h100);
        rt_tab = '{7, 7, 7};
        start_batch(3);
        wait_done(200, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_done: got no batch_done expected batch_done"); end
        n_checks++; if (res_count !== 3) begin n_errors++; $display("FAIL basic_count: got %0d expected 3", res_count); end
        n_checks++; if (prs_time_min !== 7 || prs_time_max !== 7) begin n_errors++; $display("FAIL basic_minmax: got %0d/%0d expected 7/7", prs_time_min, prs_time_max); end
        n_checks++; if (sample_idx !== 2) begin n_errors++; $display("FAIL basic_idx: got %0d expected 2", sample_idx); end
        n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || aborted !== 1'b0) begin n_errors++; $display("FAIL basic_flags: got busy=%b err=%b ab=%b expected 0 0 0", busy, err_timeout, aborted); end
        n_checks++; if (entry_q.size() != 3) begin n_errors++; $display("FAIL basic_runs: got %0d expected 3", entry_q.size()); end
        for (int i = 1; i < entry_q.size(); i++) begin
            n_checks++; if (entry_q[i] - entry_q[i-1] != 14) begin n_errors++; $display("FAIL basic_spacing%0d: got %0d expected 14", i, entry_q[i] - entry_q[i-1]); end
        end
        drain(3, 20);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (i >= got_q.size() || got_q[i] !== 32'h100 + 32'(i)) begin n_errors++; $display("FAIL basic_data%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_minmax();
        bit ok;
        int n, emin, emax;
        for (int it = 0; it < 3; it++) begin
            new_batch($urandom());
            if (it == 0) begin
                rt_tab = '{5, 9, 3};
            end else begin
                n = $urandom_range(2, 6);
                for (int k = 0; k < n; k++) rt_tab.push_back($urandom_range(1, 12));
            end
            n = rt_tab.size();
            emin = rt_tab.min()[0];
            emax = rt_tab.max()[0];
            start_batch(n);
            wait_done(400, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL mm%0d_done: got no batch_done expected batch_done", it); end
            n_checks++; if (prs_time_min !== 32'(emin) || prs_time_max !== 32'(emax)) begin n_errors++; $display("FAIL mm%0d_minmax: got %0d/%0d expected %0d/%0d", it, prs_time_min, prs_time_max, emin, emax); end
            n_checks++; if (res_count !== n) begin n_errors++; $display("FAIL mm%0d_count: got %0d expected %0d", it, res_count, n); end
            for (int i = 1; i < entry_q.size(); i++) begin
                n_checks++; if (entry_q[i] - entry_q[i-1] != rt_tab[i-1] + OVERHEAD) begin n_errors++; $display("FAIL mm%0d_spacing%0d: got %0d expected %0d", it, i, entry_q[i] - entry_q[i-1], rt_tab[i-1] + OVERHEAD); end
            end
            drain(n, 40);
            for (int i = 0; i < n; i++) begin
                n_checks++; if (i >= got_q.size() || got_q[i] !== base + 32'(i)) begin n_errors++; $display("FAIL mm%0d_data%0d: got %h expected %h", it, i, (i < got_q.size()) ? got_q[i] : 32'hx, base + 32'(i)); end
            end
        end
    endtask

    task automatic test_fifo_stall();
        bit ok;
        new_batch($urandom());
        for (int k = 0; k < 20; k++) rt_tab.push_back($urandom_range(1, 4));
        start_batch(20);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge usr_synclk);
            if (res_count == RES_DEPTH) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_fill: got count=%0d expected %0d", res_count, RES_DEPTH); end
        repeat (25) @(negedge usr_synclk);
        n_checks++; if (res_count !== RES_DEPTH || core_ap_rst !== 1'b0 || core_ap_start !== 1'b0) begin n_errors++; $display("FAIL stall_hold: got count=%0d rst=%b start=%b expected %0d 0 0", res_count, core_ap_rst, core_ap_start, RES_DEPTH); end
        n_checks++; if (sample_idx !== 16 || busy !== 1'b1 || batch_done !== 1'b0) begin n_errors++; $display("FAIL stall_state: got idx=%0d busy=%b done=%b expected 16 1 0", sample_idx, busy, batch_done); end
        repeat (5) @(negedge usr_synclk);
        n_checks++; if (res_count !== RES_DEPTH || core_ap_rst !== 1'b0) begin n_errors++; $display("FAIL stall_still: got count=%0d rst=%b expected %0d 0", res_count, core_ap_rst, RES_DEPTH); end
        drain(20, 600);
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_done: got no batch_done expected batch_done"); end
        n_checks++; if (got_q.size() != 20) begin n_errors++; $display("FAIL stall_total: got %0d expected 20", got_q.size()); end
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (i >= got_q.size() || got_q[i] !== base + 32'(i)) begin n_errors++; $display("FAIL stall_data%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, base + 32'(i)); end
        end
        n_checks++; if (res_empty !== 1'b1) begin n_errors++; $display("FAIL stall_empty: got %b expected 1", res_empty); end
    endtask

    task automatic test_timeout();
        bit ok;
        int t_err, hi;
        new_batch($urandom());
        rt_tab = '{0, 0, 0};
        start_batch(3);
        ok = 0;
        t_err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge usr_synclk);
            if (err_timeout === 1'b1) begin ok = 1; t_err = cyc_cnt; break; end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL to_flag: got err_timeout=0 expected 1"); end
        n_checks++; if (entry_q.size() < 1 || t_err - entry_q[0] != TIMEOUT_CYC) begin n_errors++; $display("FAIL to_latency: got %0d expected %0d", (entry_q.size() > 0) ? t_err - entry_q[0] : -1, TIMEOUT_CYC); end
        hi = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (core_ap_rst === 1'b1) hi++;
            if (batch_done === 1'b1) begin ok = 1; break; end
            @(negedge usr_synclk);
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL to_done: got no batch_done expected batch_done"); end
        n_checks++; if (hi != RST_HOLD) begin n_errors++; $display("FAIL to_rst_pulse: got %0d cycles expected %0d", hi, RST_HOLD); end
        n_checks++; if (res_empty !== 1'b1 || res_count !== 0) begin n_errors++; $display("FAIL to_fifo: got empty=%b count=%0d expected 1 0", res_empty, res_count); end
        n_checks++; if (entry_q.size() != 1 || sample_idx !== 0) begin n_errors++; $display("FAIL to_runs: got runs=%0d idx=%0d expected 1 0", entry_q.size(), sample_idx); end
    endtask

    task automatic test_abort();
        bit ok;
        new_batch($urandom());
        for (int k = 0; k < 5; k++) rt_tab.push_back($urandom_range(4, 9));
        start_batch(5);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge usr_synclk);
            if (entry_q.size() == 2) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ab_run1: got %0d runs expected 2", entry_q.size()); end
        abort = 1'b1;
        @(negedge usr_synclk);
        abort = 1'b0;
        wait_done(200, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ab_done: got no batch_done expected batch_done"); end
        n_checks++; if (aborted !== 1'b1 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL ab_flags: got ab=%b err=%b expected 1 0", aborted, err_timeout); end
        n_checks++; if (sample_idx !== 1 || entry_q.size() != 2) begin n_errors++; $display("FAIL ab_idx: got idx=%0d runs=%0d expected 1 2", sample_idx, entry_q.size()); end
        drain(2, 20);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (i >= got_q.size() || got_q[i] !== base + 32'(i)) begin n_errors++; $display("FAIL ab_data%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, base + 32'(i)); end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        new_batch($urandom());
        rt_tab = '{8, 8, 8, 8, 8};
        start_batch(5);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge usr_synclk);
            if (entry_q.size() == 3) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mr_run2: got %0d runs expected 3", entry_q.size()); end
        repeat (2) @(negedge usr_synclk);
        sys_rst_p = 1'b1;
        @(negedge usr_synclk);
        n_checks++; if (core_ap_start !== 1'b0 || core_ap_rst !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL mr_ctrl: got start=%b rst=%b busy=%b expected 0 1 0", core_ap_start, core_ap_rst, busy); end
        n_checks++; if (sample_idx !== 0 || res_count !== 0 || res_empty !== 1'b1) begin n_errors++; $display("FAIL mr_fifo: got idx=%0d count=%0d empty=%b expected 0 0 1", sample_idx, res_count, res_empty); end
        n_checks++; if (prs_time_min !== 32'hFFFF_FFFF || prs_time_max !== 0 || {batch_done, err_timeout, aborted} !== 3'b0) begin n_errors++; $display("FAIL mr_stats: got %h/%h flags=%b expected ffffffff/0 000", prs_time_min, prs_time_max, {batch_done, err_timeout, aborted}); end
        sys_rst_p = 1'b0;
        repeat (30) @(negedge usr_synclk);
        n_checks++; if (entry_q.size() != 3 || busy !== 1'b0 || core_ap_rst !== 1'b0) begin n_errors++; $display("FAIL mr_idle: got runs=%0d busy=%b rst=%b expected 3 0 0", entry_q.size(), busy, core_ap_rst); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        new_batch($urandom());
        rt_tab = '{6, 6};
        start_batch(2);
        repeat (3) @(negedge usr_synclk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL bi_busy: got %b expected 1", busy); end
        batch_start = 1'b1;
        batch_len   = IDX_W'(7);
        @(negedge usr_synclk);
        batch_start = 1'b0;
        wait_done(200, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bi_done: got no batch_done expected batch_done"); end
        n_checks++; if (entry_q.size() != 2 || sample_idx !== 1 || res_count !== 2) begin n_errors++; $display("FAIL bi_runs: got runs=%0d idx=%0d count=%0d expected 2 1 2", entry_q.size(), sample_idx, res_count); end
    endtask

    task automatic test_zero_len();
        bit ok;
        new_batch($urandom());
        @(negedge usr_synclk);
        abort = 1'b1;
        @(negedge usr_synclk);
        abort = 1'b0;
        start_batch(0);
        wait_done(20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL zl_done: got no batch_done expected batch_done"); end
        repeat (5) @(negedge usr_synclk);
        n_checks++; if (entry_q.size() != 0 || res_count !== 0 || busy !== 1'b0) begin n_errors++; $display("FAIL zl_runs: got runs=%0d count=%0d busy=%b expected 0 0 0", entry_q.size(), res_count, busy); end
        n_checks++; if (aborted !== 1'b0 || sample_idx !== 0) begin n_errors++; $display("FAIL zl_flags: got ab=%b idx=%0d expected 0 0", aborted, sample_idx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_minmax();
        test_fifo_stall();
        test_timeout();
        test_abort();
        test_mid_reset();
        test_busy_ignore();
        test_zero_len();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
